// File: rtl/hd44780_ctrl.sv
// hd44780_ctrl: HD44780 character-LCD controller with a tick-driven bus sequencer.
// Runs the power-on init by itself, then forwards host command/data bytes
// to the panel in 8-bit or 4-bit bus mode.
// Optional feature: define HD44780_LINEWRAP_EN to track the cursor and insert a
// set-DDRAM-address command whenever a data write runs off the end of a row.
// Host handshake: a byte moves on the rising clk edge where wr_valid and wr_ready
// are both 1; wr_ready is high only while idle after init, drops on the cycle
// after acceptance, and returns on the cycle after the post-write wait ends.
module hd44780_ctrl #(
  parameter int TICK_DIV    = 2048,
  parameter int BUS_WIDTH   = 8,
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int POR_TICKS   = 100,
  parameter int SHORT_TICKS = 1,
  parameter int LONG_TICKS  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 wr_rs,
  input  logic [7:0]           wr_data,
  output logic                 init_done,
  output logic [BUS_WIDTH-1:0] lcd_db,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e
);

  localparam int DIV_W    = $clog2(TICK_DIV);
  localparam int WAIT_A   = (POR_TICKS > LONG_TICKS) ? POR_TICKS : LONG_TICKS;
  localparam int WAIT_MAX = (WAIT_A > SHORT_TICKS) ? WAIT_A : SHORT_TICKS;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);
  localparam int INIT_LEN = (BUS_WIDTH == 4) ? 8 : 7;

  typedef enum logic [2:0] {
    ST_POR_WAIT, ST_INIT, ST_IDLE, ST_SETUP, ST_E_HI, ST_E_LO, ST_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           byte_q, byte_d;
  logic                 rs_byte_q, rs_byte_d;
  logic                 single_q, single_d;
  logic                 nib_q, nib_d;
  logic                 init_done_q, init_done_d;
  logic                 ready_q, ready_d;
  logic                 e_q, e_d;
  logic                 rs_q, rs_d;
  logic [BUS_WIDTH-1:0] db_q, db_d;
  logic                 tick;
  logic                 is_long;
`ifdef HD44780_LINEWRAP_EN
  logic                 row_q, row_d;
  logic [6:0]           col_q, col_d;
  logic                 wrap_pend_q, wrap_pend_d;
  logic                 next_row;
`endif

  // Init table entry {single_nibble, byte}; 4-bit mode starts with four lone nibbles.
  function automatic logic [8:0] init_entry(input logic [3:0] idx);
    logic [8:0] ent;
    ent = {1'b0, 8'h06};
    if (BUS_WIDTH == 4) begin
      case (idx)
        4'd0, 4'd1, 4'd2: ent = {1'b1, 8'h30};
        4'd3:             ent = {1'b1, 8'h20};
        4'd4:             ent = {1'b0, (ROWS == 2) ? 8'h28 : 8'h20};
        4'd5:             ent = {1'b0, 8'h0C};
        4'd6:             ent = {1'b0, 8'h01};
        default:          ent = {1'b0, 8'h06};
      endcase
    end else begin
      case (idx)
        4'd0, 4'd1, 4'd2: ent = {1'b0, 8'h30};
        4'd3:             ent = {1'b0, (ROWS == 2) ? 8'h38 : 8'h30};
        4'd4:             ent = {1'b0, 8'h0C};
        4'd5:             ent = {1'b0, 8'h01};
        default:          ent = {1'b0, 8'h06};
      endcase
    end
    return ent;
  endfunction

  assign tick    = (div_q == DIV_W'(TICK_DIV - 1));
  assign is_long = !rs_byte_q && ((byte_q == 8'h01) || (byte_q == 8'h02));
`ifdef HD44780_LINEWRAP_EN
  assign next_row = (ROWS == 2) ? ~row_q : 1'b0;
`endif

  // Next-state, byte loading and pin values for the bus sequencer.
  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + DIV_W'(1);
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    rs_byte_d   = rs_byte_q;
    single_d    = single_q;
    nib_d       = nib_q;
    init_done_d = init_done_q;
    db_d        = db_q;
    rs_d        = rs_q;
`ifdef HD44780_LINEWRAP_EN
    row_d       = row_q;
    col_d       = col_q;
    wrap_pend_d = wrap_pend_q;
`endif
    case (state_q)
      ST_POR_WAIT: if (tick) begin
        if (cnt_q == CNT_W'(1)) state_d = ST_INIT;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_INIT: begin
        {single_d, byte_d} = init_entry(idx_q);
        rs_byte_d = 1'b0;
        nib_d     = 1'b0;
        idx_d     = idx_q + 4'd1;
        state_d   = ST_SETUP;
      end
      ST_IDLE: if (wr_valid && ready_q) begin
        byte_d    = wr_data;
        rs_byte_d = wr_rs;
        single_d  = 1'b0;
        nib_d     = 1'b0;
        state_d   = ST_SETUP;
`ifdef HD44780_LINEWRAP_EN
        if (wr_rs) begin
          if (col_q + 7'd1 == 7'(COLS)) wrap_pend_d = 1'b1;
          else                          col_d       = col_q + 7'd1;
        end else if ((wr_data == 8'h01) || (wr_data == 8'h02)) begin
          row_d = 1'b0;
          col_d = 7'd0;
        end else if (wr_data[7]) begin
          row_d = (ROWS == 2) ? wr_data[6] : 1'b0;
          col_d = {1'b0, wr_data[5:0]};
        end
`endif
      end
      ST_SETUP: if (tick) state_d = ST_E_HI;
      ST_E_HI:  if (tick) state_d = ST_E_LO;
      ST_E_LO: if (tick) begin
        if ((BUS_WIDTH == 4) && !single_q && !nib_q) begin
          nib_d   = 1'b1;
          state_d = ST_SETUP;
        end else begin
          cnt_d   = is_long ? CNT_W'(LONG_TICKS) : CNT_W'(SHORT_TICKS);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: if (tick) begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!init_done_q) begin
          if (idx_q == 4'(INIT_LEN)) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_INIT;
          end
        end else begin
          state_d = ST_IDLE;
`ifdef HD44780_LINEWRAP_EN
          if (wrap_pend_q) begin
            byte_d      = {1'b1, next_row, 6'h00};
            rs_byte_d   = 1'b0;
            single_d    = 1'b0;
            nib_d       = 1'b0;
            row_d       = next_row;
            col_d       = 7'd0;
            wrap_pend_d = 1'b0;
            state_d     = ST_SETUP;
          end
`endif
        end
      end
      default: state_d = ST_POR_WAIT;
    endcase
    // Pins are registered; db/rs change only on entry to SETUP and hold otherwise.
    e_d     = (state_d == ST_E_HI);
    ready_d = (state_d == ST_IDLE) && init_done_d;
    if (state_d == ST_SETUP) begin
      rs_d = rs_byte_d;
      if (BUS_WIDTH == 4) db_d = BUS_WIDTH'(nib_d ? byte_d[3:0] : byte_d[7:4]);
      else                db_d = BUS_WIDTH'(byte_d);
    end
  end

  // State and pin registers; reset drops lcd_e immediately and restarts the POR wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_POR_WAIT;
      div_q       <= '0;
      cnt_q       <= CNT_W'(POR_TICKS);
      idx_q       <= 4'd0;
      byte_q      <= 8'h00;
      rs_byte_q   <= 1'b0;
      single_q    <= 1'b0;
      nib_q       <= 1'b0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      db_q        <= '0;
`ifdef HD44780_LINEWRAP_EN
      row_q       <= 1'b0;
      col_q       <= 7'd0;
      wrap_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      rs_byte_q   <= rs_byte_d;
      single_q    <= single_d;
      nib_q       <= nib_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      db_q        <= db_d;
`ifdef HD44780_LINEWRAP_EN
      row_q       <= row_d;
      col_q       <= col_d;
      wrap_pend_q <= wrap_pend_d;
`endif
    end
  end

  assign wr_ready  = ready_q;
  assign init_done = init_done_q;
  assign lcd_db    = db_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = e_q;

endmodule

// File: tb/tb_hd44780_ctrl.sv
// tb_hd44780_ctrl: runs an 8-bit and a 4-bit controller side by side against a
// bus-level model: every e pulse must carry the next expected (rs, db), each bus
// phase lasts one tick, and the post-write wait is the short or long tick count.
module tb_hd44780_ctrl;
  localparam int TD    = 4;
  localparam int POR   = 3;
  localparam int LONG  = 4;
  localparam int SHORT = 1;
  localparam int COLS  = 16;
  localparam int ROWS  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic       wr_valid [2];
  logic       wr_rs [2];
  logic [7:0] wr_data [2];
  logic       wr_ready_v [2];
  logic       init_done_v [2];
  logic       lcd_rs_v [2];
  logic       lcd_rw_v [2];
  logic       lcd_e_v [2];
  logic [7:0] lcd_db8;
  logic [3:0] lcd_db4;

  hd44780_ctrl #(.TICK_DIV(TD), .BUS_WIDTH(8), .COLS(COLS), .ROWS(ROWS),
    .POR_TICKS(POR), .SHORT_TICKS(SHORT), .LONG_TICKS(LONG)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid[0]), .wr_ready(wr_ready_v[0]),
    .wr_rs(wr_rs[0]), .wr_data(wr_data[0]), .init_done(init_done_v[0]),
    .lcd_db(lcd_db8), .lcd_rs(lcd_rs_v[0]), .lcd_rw(lcd_rw_v[0]), .lcd_e(lcd_e_v[0]));

  hd44780_ctrl #(.TICK_DIV(TD), .BUS_WIDTH(4), .COLS(COLS), .ROWS(ROWS),
    .POR_TICKS(POR), .SHORT_TICKS(SHORT), .LONG_TICKS(LONG)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid[1]), .wr_ready(wr_ready_v[1]),
    .wr_rs(wr_rs[1]), .wr_data(wr_data[1]), .init_done(init_done_v[1]),
    .lcd_db(lcd_db4), .lcd_rs(lcd_rs_v[1]), .lcd_rw(lcd_rw_v[1]), .lcd_e(lcd_e_v[1]));

  // scoreboard: entry = {is_init, rs, db[7:0], wait_ticks[5:0]}
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int cur_row [2];
  int cur_col [2];

  function automatic void chk(string name, int k, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at cycle %0d", name, k, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] db_of(int k);
    return (k == 0) ? lcd_db8 : {4'h0, lcd_db4};
  endfunction

  function automatic void q_push(int k, logic [15:0] v);
    if (k == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  function automatic int q_size(int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [15:0] q_pop(int k);
    return (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
  endfunction

  // One byte becomes one (8-bit) or two (4-bit) bus writes; only the last carries the wait.
  function automatic void model_byte(int k, bit init, bit rs, logic [7:0] b, bit single);
    logic [5:0] w;
    w = (!rs && (b == 8'h01 || b == 8'h02)) ? 6'(LONG) : 6'(SHORT);
    if (k == 0) q_push(k, {init, rs, b, w});
    else if (single) q_push(k, {init, rs, 4'h0, b[7:4], w});
    else begin
      q_push(k, {init, rs, 4'h0, b[7:4], 6'd0});
      q_push(k, {init, rs, 4'h0, b[3:0], w});
    end
  endfunction

  function automatic void model_init(int k);
    if (k == 0) exp_q0.delete();
    else        exp_q1.delete();
    cur_row[k] = 0;
    cur_col[k] = 0;
    if (k == 0) begin
      model_byte(k, 1, 0, 8'h30, 0);
      model_byte(k, 1, 0, 8'h30, 0);
      model_byte(k, 1, 0, 8'h30, 0);
      model_byte(k, 1, 0, (ROWS == 2) ? 8'h38 : 8'h30, 0);
    end else begin
      model_byte(k, 1, 0, 8'h30, 1);
      model_byte(k, 1, 0, 8'h30, 1);
      model_byte(k, 1, 0, 8'h30, 1);
      model_byte(k, 1, 0, 8'h20, 1);
      model_byte(k, 1, 0, (ROWS == 2) ? 8'h28 : 8'h20, 0);
    end
    model_byte(k, 1, 0, 8'h0C, 0);
    model_byte(k, 1, 0, 8'h01, 0);
    model_byte(k, 1, 0, 8'h06, 0);
  endfunction

  function automatic void model_host(int k, bit rs, logic [7:0] b);
    model_byte(k, 0, rs, b, 0);
`ifdef HD44780_LINEWRAP_EN
    if (rs) begin
      cur_col[k]++;
      if (cur_col[k] == COLS) begin
        cur_row[k] = (ROWS == 2) ? 1 - cur_row[k] : 0;
        cur_col[k] = 0;
        model_byte(k, 0, 0, (cur_row[k] == 1) ? 8'hC0 : 8'h80, 0);
      end
    end else if (b == 8'h01 || b == 8'h02) begin
      cur_row[k] = 0;
      cur_col[k] = 0;
    end else if (b[7]) begin
      cur_row[k] = (ROWS == 2) ? int'(b[6]) : 0;
      cur_col[k] = int'(b[5:0]);
    end
`endif
  endfunction

  // compare process: bus contents at each e fall, phase timing, handshake
  bit         e_prev [2], r_prev [2], armed [2], seen_first [2], acc_prev [2];
  int         fall_cyc [2], rise_cyc [2], wgap [2], falls [2], last_ready_gap [2];
  logic [7:0] last_db [2], prev_db [2];
  logic       last_rs [2];

  initial begin
    logic [15:0] ent;
    logic e, r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          e_prev[k] = 0; r_prev[k] = 0; armed[k] = 0; seen_first[k] = 0;
          acc_prev[k] = 0; falls[k] = 0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          e = lcd_e_v[k];
          r = wr_ready_v[k];
          if (acc_prev[k]) chk("ready_drop_after_accept", k, r, 0);
          if (e && !e_prev[k]) begin
            if (!seen_first[k]) begin
              chk("first_e_rise", k, cyc, (POR + 1) * TD);
              seen_first[k] = 1;
            end else if (armed[k]) begin
              chk("e_gap", k, cyc - fall_cyc[k], (wgap[k] + 2) * TD);
              armed[k] = 0;
            end
            rise_cyc[k] = cyc;
          end
          if (!e && e_prev[k]) begin
            falls[k]++;
            chk("e_width", k, cyc - rise_cyc[k], TD);
            chk("rw_low", k, lcd_rw_v[k], 0);
            chk("bus_write_expected", k, q_size(k) > 0, 1);
            if (q_size(k) > 0) begin
              ent = q_pop(k);
              chk("db", k, db_of(k), ent[13:6]);
              chk("rs", k, lcd_rs_v[k], ent[14]);
              chk("init_done_at_write", k, init_done_v[k], !ent[15]);
              prev_db[k] = last_db[k];
              last_db[k] = db_of(k);
              last_rs[k] = lcd_rs_v[k];
              armed[k] = 1;
              fall_cyc[k] = cyc;
              wgap[k] = int'(ent[5:0]);
            end
          end
          if (r && !r_prev[k]) begin
            chk("ready_after_write", k, armed[k], 1);
            if (armed[k]) begin
              last_ready_gap[k] = cyc - fall_cyc[k];
              chk("ready_gap", k, last_ready_gap[k], (wgap[k] + 1) * TD);
              armed[k] = 0;
            end
            chk("init_done_with_ready", k, init_done_v[k], 1);
            chk("writes_drained", k, q_size(k), 0);
          end
          acc_prev[k] = r && wr_valid[k];
          e_prev[k] = e;
          r_prev[k] = r;
        end
      end
    end
  end

  // driver tasks
  task automatic send(input int k, input bit rs, input logic [7:0] d);
    bit ok;
    ok = 0;
    wr_rs[k] = rs;
    wr_data[k] = d;
    wr_valid[k] = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (wr_ready_v[k]) begin
        ok = 1;
        break;
      end
    end
    chk("accept_timeout", k, ok, 1);
    if (ok) begin
      @(posedge clk);
      #1;
      model_host(k, rs, d);
    end
    wr_valid[k] = 1'b0;
  endtask

  task automatic wait_ready(input int k);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (wr_ready_v[k]) begin
        ok = 1;
        break;
      end
    end
    chk("ready_timeout", k, ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int k, input int n);
    int r;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) send(k, 1, 8'($urandom_range(0, 255)));
      else if (r == 6) send(k, 0, 8'($urandom_range(1, 2)));
      else if (r == 7) begin
        d = 8'h80 | 8'($urandom_range(0, 1) << 6) | 8'($urandom_range(0, COLS - 1));
        send(k, 0, d);
      end else send(k, 0, 8'h0C + 8'($urandom_range(0, 3)));
      r = $urandom_range(0, 3);
      if (r > 0) begin
        repeat (r) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      wr_valid[k] = 1'b0;
      wr_rs[k] = 1'b0;
      wr_data[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_e", k, lcd_e_v[k], 0);
      chk("reset_rs", k, lcd_rs_v[k], 0);
      chk("reset_db", k, db_of(k), 0);
      chk("reset_rw", k, lcd_rw_v[k], 0);
      chk("reset_ready", k, wr_ready_v[k], 0);
      chk("reset_init_done", k, init_done_v[k], 0);
      model_init(k);
    end
    #1 rst_n = 1'b1;

    // abort the first init in the middle of an e-high phase
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lcd_e_v[0]) begin
        ok = 1;
        break;
      end
    end
    chk("first_e_timeout", 0, ok, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("e_async_drop", 0, lcd_e_v[0], 0);
    chk("e_async_drop", 1, lcd_e_v[1], 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init_done_after_reset", 0, init_done_v[0], 0);
    model_init(0);
    model_init(1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_ready(0);
    wait_ready(1);
    chk("init_pulse_count", 0, falls[0], 7);
    chk("init_pulse_count", 1, falls[1], 12);

    // 4-bit nibble split and long/short waits
    send(1, 1, 8'h41);
    wait_ready(1);
    chk("nibble_hi", 1, prev_db[1], 8'h04);
    chk("nibble_lo", 1, last_db[1], 8'h01);
    chk("nibble_rs", 1, last_rs[1], 1);
    send(0, 0, 8'h01);
    wait_ready(0);
    chk("clear_wait_cycles", 0, last_ready_gap[0], 20);
    send(0, 0, 8'h0C);
    wait_ready(0);
    chk("short_wait_cycles", 0, last_ready_gap[0], 8);

    // wr_valid held high across two bytes
    send(0, 1, 8'h48);
    send(0, 1, 8'h49);
    wait_ready(0);
    chk("held_first", 0, prev_db[0], 8'h48);
    chk("held_second", 0, last_db[0], 8'h49);

    // a full row of data, then another
    send(0, 0, 8'h80);
    d = 8'h00;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(32, 126));
      send(0, 1, d);
    end
    wait_ready(0);
`ifdef HD44780_LINEWRAP_EN
    chk("wrap_to_row1", 0, last_db[0], 8'hC0);
    chk("wrap_rs", 0, last_rs[0], 0);
`else
    chk("row_end_verbatim", 0, last_db[0], d);
    chk("row_end_rs", 0, last_rs[0], 1);
`endif
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(32, 126));
      send(0, 1, d);
    end
    wait_ready(0);
`ifdef HD44780_LINEWRAP_EN
    chk("wrap_to_row0", 0, last_db[0], 8'h80);
`else
    chk("row_end_verbatim", 0, last_db[0], d);
`endif

    // randomized traffic on both controllers at once
    fork
      run_random(0, 40);
      run_random(1, 40);
    join
    wait_ready(0);
    wait_ready(1);
    chk("final_queue_empty", 0, q_size(0), 0);
    chk("final_queue_empty", 1, q_size(1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
